game_fsm: RTL and testbench
===========================

# game_fsm

Top-level game sequencer. It sits between the debouncer outputs and the gameplay blocks (player, laser, invaders, missiles, score logic). It tracks the attract, ready, play and game-over phases, and issues one-cycle restart and new-wave pulses to those blocks. It also gates all sprite motion through a single `run` enable, and decides game over from the lives count and the invader formation's depth.

## Interface
Parameters:
- `READY_FRAMES`, default 120: frames of countdown between a start or new wave and live play.
- `OVER_LOCKOUT`, default 60: frames after game over during which `shoot` is ignored.
- `Y_LIMIT`, default 400: invader formation y at or beyond which the invaders have landed.
- `MAX_WAVE`, default 15: saturation value of the wave counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pixel clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `frame`  in  1  one-cycle pulse at end of each VGA frame.
- `shoot`  in  1  debounced shoot level; start/continue key.
- `arst`  in  1  debounced user-restart level; synchronous abort.
- `lives`  in  2  remaining lives from score logic.
- `invaders`  in  55  alive bitmap of the formation.
- `invaders_y`  in  10  formation top-left y.
- `state`  out  2  0=ATTRACT, 1=READY, 2=PLAY, 3=OVER.
- `run`  out  1  high only in PLAY; motion/fire enable for sprite blocks.
- `game_rst`  out  1  one-cycle pulse: reset lives, score, sprites.
- `wave_rst`  out  1  one-cycle pulse: respawn formation only.
- `wave`  out  4  current wave number, 0 in ATTRACT.
- `game_over`  out  1  high in OVER.

## Operation
- Shoot edge: `shoot_q` is registered; `start = shoot & ~shoot_q`. `shoot_q` resets to 0.
- Frame counter: 8 bits (`fcnt`), loaded on state entry.
- Reset values: `state`=ATTRACT, `run`=0, `game_rst`=0, `wave_rst`=0, `wave`=0, `game_over`=0, `fcnt`=0.
- ATTRACT:
  - On `start`: pulse `game_rst`, set `wave`=1, load `fcnt`=READY_FRAMES, go to READY.
- READY:
  - On each `frame` with `fcnt`≠0, decrement `fcnt`.
  - On a `frame` with `fcnt`=0, go to PLAY.
  - `start` is ignored.
- PLAY (evaluated only on cycles with `frame`=1), in priority order:
  1. If `lives`==0 or `invaders_y`≥Y_LIMIT: go to OVER and load `fcnt`=OVER_LOCKOUT.
  2. Else if `invaders`==0: pulse `wave_rst`, set `wave`=min(`wave`+1, MAX_WAVE), load `fcnt`=READY_FRAMES, go to READY.
  3. Else: hold.
- OVER:
  - Decrement `fcnt` on `frame` until it reaches 0.
  - `start` while `fcnt`≠0 is ignored.
  - `start` with `fcnt`=0 behaves exactly as in ATTRACT: pulse `game_rst`, `wave`=1, go to READY.
- `arst` (level, any state, highest priority over all of the above):
  - Pulse `game_rst`, set `wave`=0, go to ATTRACT.
  - While `arst` is held, stay in ATTRACT with `game_rst` high every cycle.
- Outputs are decoded from registered state:
  - `run`=(state==PLAY).
  - `game_over`=(state==OVER).
- A `frame` in the same cycle as `start` in ATTRACT does not decrement the newly loaded `fcnt`.

## Timing
- `game_rst` and `wave_rst` are registered: asserted the cycle after the triggering edge or `frame`, for exactly one cycle (except under held `arst`).
- `state` updates on the same edge that asserts the pulse, so downstream blocks see the pulse with the new state already present.
- Start to PLAY: READY_FRAMES+1 `frame` pulses after `start`.
- `run` drops on the edge after the deciding `frame`, so sprites freeze within one clock.
- `rst` asserted mid-operation clears everything asynchronously. No pulse is emitted on release.
- `wave` holds at MAX_WAVE; no wrap to 0.

## Test plan
- Reset with `shoot`=0: all outputs 0, `state`=0. Hold for 10 frames: no change.
- Start: `shoot` rises in ATTRACT → `game_rst`=1 for exactly 1 cycle, `state`=1, `wave`=1. After 121 `frame` pulses (READY_FRAMES=120) → `state`=2, `run`=1.
- Clear wave: in PLAY with `wave`=15 and `invaders`=0 on a `frame` → `wave_rst` 1-cycle pulse, `wave` stays 15, `state`=1, `game_rst` stays 0.
- Death priority: `lives`=0 and `invaders`=0 on the same `frame` → `state`=3, `game_over`=1, `run`=0, no `wave_rst`. The same holds with `lives`=2 and `invaders_y`=400.
- Lockout: `shoot` edge 10 frames into OVER → ignored. `shoot` edge after 61 frames → `game_rst` pulse, `state`=1, `wave`=1.
- Abort: `arst` held 5 cycles mid-PLAY → `game_rst` high 5 cycles, `state`=0, `wave`=0. `rst` asserted in READY → immediate return to reset values.

Source files
------------

// File: rtl/game_fsm.sv
// Game sequencer: attract / ready / play / over phases, restart and new-wave pulses,
// and the single motion enable for all sprite blocks.
module game_fsm #(
  parameter int READY_FRAMES = 120,
  parameter int OVER_LOCKOUT = 60,
  parameter int Y_LIMIT      = 400,
  parameter int MAX_WAVE     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        shoot,
  input  logic        arst,
  input  logic [1:0]  lives,
  input  logic [54:0] invaders,
  input  logic [9:0]  invaders_y,
  output logic [1:0]  state,
  output logic        run,
  output logic        game_rst,
  output logic        wave_rst,
  output logic [3:0]  wave,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'd0,
    ST_READY   = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] fcnt_q, fcnt_d;
  logic [3:0] wave_q, wave_d;
  logic       shoot_q;
  logic       game_rst_q, game_rst_d;
  logic       wave_rst_q, wave_rst_d;
  logic       run_q, game_over_q;
  logic       start;
  logic       died;
  logic [3:0] wave_next;

  assign start     = shoot & ~shoot_q;
  assign died      = (lives == 2'd0) || (invaders_y >= 10'(Y_LIMIT));
  assign wave_next = (wave_q >= 4'(MAX_WAVE)) ? 4'(MAX_WAVE) : wave_q + 4'd1;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    wave_d     = wave_q;
    game_rst_d = 1'b0;
    wave_rst_d = 1'b0;

    if (arst) begin
      state_d    = ST_ATTRACT;
      fcnt_d     = 8'd0;
      wave_d     = 4'd0;
      game_rst_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_ATTRACT: begin
          if (start) begin
            state_d    = ST_READY;
            fcnt_d     = 8'(READY_FRAMES);
            wave_d     = 4'd1;
            game_rst_d = 1'b1;
          end
        end
        ST_READY: begin
          if (frame) begin
            if (fcnt_q != 8'd0) fcnt_d = fcnt_q - 8'd1;
            else                state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Death outranks a cleared formation on the same frame.
          if (frame) begin
            if (died) begin
              state_d = ST_OVER;
              fcnt_d  = 8'(OVER_LOCKOUT);
            end else if (invaders == '0) begin
              state_d    = ST_READY;
              fcnt_d     = 8'(READY_FRAMES);
              wave_d     = wave_next;
              wave_rst_d = 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (start && fcnt_q == 8'd0) begin
            state_d    = ST_READY;
            fcnt_d     = 8'(READY_FRAMES);
            wave_d     = 4'd1;
            game_rst_d = 1'b1;
          end else if (frame && fcnt_q != 8'd0) begin
            fcnt_d = fcnt_q - 8'd1;
          end
        end
        default: state_d = ST_ATTRACT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ATTRACT;
      fcnt_q      <= 8'd0;
      wave_q      <= 4'd0;
      shoot_q     <= 1'b0;
      game_rst_q  <= 1'b0;
      wave_rst_q  <= 1'b0;
      run_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      wave_q      <= wave_d;
      shoot_q     <= shoot;
      game_rst_q  <= game_rst_d;
      wave_rst_q  <= wave_rst_d;
      run_q       <= (state_d == ST_PLAY);
      game_over_q <= (state_d == ST_OVER);
    end
  end

  assign state     = state_q;
  assign run       = run_q;
  assign game_rst  = game_rst_q;
  assign wave_rst  = wave_rst_q;
  assign wave      = wave_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with default parameters; expected values are hand-derived.
module tb_game_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        shoot;
  logic        arst;
  logic [1:0]  lives;
  logic [54:0] invaders;
  logic [9:0]  invaders_y;
  logic [1:0]  state;
  logic        run;
  logic        game_rst;
  logic        wave_rst;
  logic [3:0]  wave;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  game_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .frame      (frame),
    .shoot      (shoot),
    .arst       (arst),
    .lives      (lives),
    .invaders   (invaders),
    .invaders_y (invaders_y),
    .state      (state),
    .run        (run),
    .game_rst   (game_rst),
    .wave_rst   (wave_rst),
    .wave       (wave),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame pulse; outputs reflect the edge that consumed it.
  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_pulse();
      tick();
    end
  endtask

  task automatic shoot_edge();
    shoot = 1'b1;
    tick();
  endtask

  initial begin
    logic [3:0] exp_wave;
    rst = 1'b1; frame = 1'b0; shoot = 1'b0; arst = 1'b0;
    lives = 2'd3; invaders = '1; invaders_y = 10'd0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_run", run, 0);
    check("rst_game_rst", game_rst, 0);
    check("rst_wave_rst", wave_rst, 0);
    check("rst_wave", wave, 0);
    check("rst_game_over", game_over, 0);
    rst = 1'b0;
    tick();
    check("rst_release_no_pulse", game_rst, 0);
    frames(10);
    check("attract_hold_state", state, 0);
    check("attract_hold_game_rst", game_rst, 0);

    // Start with a coincident frame: the loaded count must not be decremented.
    shoot = 1'b1; frame = 1'b1;
    tick();
    frame = 1'b0;
    check("start_game_rst", game_rst, 1);
    check("start_state", state, 1);
    check("start_wave", wave, 1);
    tick();
    check("start_game_rst_1cyc", game_rst, 0);
    shoot = 1'b0;
    frames(5);
    shoot_edge();
    check("ready_ignore_start_rst", game_rst, 0);
    check("ready_ignore_start_state", state, 1);
    shoot = 1'b0;
    frames(115);
    check("ready_after_120", state, 1);
    check("ready_run_low", run, 0);
    frame_pulse();
    check("play_state", state, 2);
    check("play_run", run, 1);
    frame_pulse();
    check("play_hold", state, 2);

    // Clear waves until the counter saturates, then once more at the limit.
    exp_wave = 4'd1;
    for (int k = 0; k < 15; k++) begin
      exp_wave = (exp_wave == 4'd15) ? 4'd15 : exp_wave + 4'd1;
      invaders = '0;
      frame_pulse();
      check("clear_wave_rst", wave_rst, 1);
      check("clear_wave", wave, exp_wave);
      check("clear_state", state, 1);
      check("clear_no_game_rst", game_rst, 0);
      check("clear_run_low", run, 0);
      tick();
      check("clear_wave_rst_1cyc", wave_rst, 0);
      invaders = '1;
      frames(120);
      frame_pulse();
      check("clear_back_to_play", state, 2);
    end
    check("wave_saturated", wave, 15);

    // Death outranks a cleared formation.
    lives = 2'd0; invaders = '0;
    frame_pulse();
    check("death_state", state, 3);
    check("death_game_over", game_over, 1);
    check("death_run", run, 0);
    check("death_no_wave_rst", wave_rst, 0);
    lives = 2'd3; invaders = '1;
    frames(10);
    shoot_edge();
    check("lockout_no_rst", game_rst, 0);
    check("lockout_state", state, 3);
    shoot = 1'b0;
    frames(51);
    shoot_edge();
    check("restart_game_rst", game_rst, 1);
    check("restart_state", state, 1);
    check("restart_wave", wave, 1);
    check("restart_game_over_low", game_over, 0);
    shoot = 1'b0;
    frames(120);
    frame_pulse();
    check("replay_state", state, 2);

    // Landing boundary: 399 holds, 400 ends the game even with lives left.
    lives = 2'd2; invaders_y = 10'd399;
    frame_pulse();
    check("y399_hold", state, 2);
    invaders_y = 10'd400; invaders = '0;
    frame_pulse();
    check("y400_state", state, 3);
    check("y400_no_wave_rst", wave_rst, 0);
    check("y400_wave_kept", wave, 1);
    invaders_y = 10'd0; invaders = '1; lives = 2'd3;
    frames(60);
    shoot_edge();
    check("restart2_state", state, 1);
    shoot = 1'b0;
    frames(120);
    frame_pulse();
    check("replay2_state", state, 2);

    // Held abort.
    arst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_game_rst", game_rst, 1);
      check("abort_state", state, 0);
      check("abort_wave", wave, 0);
    end
    arst = 1'b0;
    tick();
    check("abort_release_rst", game_rst, 0);
    check("abort_release_state", state, 0);

    // Asynchronous reset from READY.
    shoot_edge();
    check("pre_rst_state", state, 1);
    shoot = 1'b0;
    frames(3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_wave", wave, 0);
    check("async_rst_run", run, 0);
    check("async_rst_game_rst", game_rst, 0);
    tick();
    rst = 1'b0;
    tick();
    check("async_rst_release_pulse", game_rst, 0);
    check("async_rst_release_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
